// File: rtl/bit_set_enumerator.sv
// Expands a captured bitmask into a stream of one beat per set bit, lowest index first.
// Every beat carries its bit index, one-hot mask, sequence number and the word's set-bit total.
module bit_set_enumerator #(
    parameter  int WORD_WIDTH  = 8,
    localparam int INDEX_WIDTH = $clog2(WORD_WIDTH),
    localparam int COUNT_WIDTH = $clog2(WORD_WIDTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [WORD_WIDTH-1:0]  input_word,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [INDEX_WIDTH-1:0] output_index,
    output logic [WORD_WIDTH-1:0]  output_onehot,
    output logic [COUNT_WIDTH-1:0] output_seq,
    output logic [COUNT_WIDTH-1:0] output_total,
    output logic                   output_last,
    output logic                   output_none
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q,     state_d;
    logic [WORD_WIDTH-1:0]  remaining_q, remaining_d;
    logic [COUNT_WIDTH-1:0] seq_q,       seq_d;
    logic [COUNT_WIDTH-1:0] total_q,     total_d;
    logic                   none_q,      none_d;

    logic                   busy;
    logic [WORD_WIDTH-1:0]  lowest_bit;
    logic [WORD_WIDTH-1:0]  remaining_cleared;
    logic                   single_bit;
    logic                   last_beat;
    logic [COUNT_WIDTH-1:0] input_popcount;
    logic [INDEX_WIDTH-1:0] lowest_index;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            seq_q       <= '0;
            total_q     <= '0;
            none_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            seq_q       <= seq_d;
            total_q     <= total_d;
            none_q      <= none_d;
        end
    end

    // Two's-complement isolate/clear of the lowest set bit of the remaining mask.
    assign lowest_bit        = remaining_q & (~remaining_q + WORD_WIDTH'(1));
    assign remaining_cleared = remaining_q & (remaining_q - WORD_WIDTH'(1));
    assign single_bit        = (remaining_q != '0) && (remaining_cleared == '0);
    assign busy              = (state_q == BUSY);
    assign last_beat         = single_bit || none_q;

    always_comb begin
        input_popcount = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            input_popcount = input_popcount + COUNT_WIDTH'(input_word[i]);
        end
    end

    always_comb begin
        lowest_index = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (lowest_bit[i]) begin
                lowest_index = INDEX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        seq_d       = seq_q;
        total_d     = total_q;
        none_d      = none_q;
        case (state_q)
            IDLE: begin
                if (input_valid) begin
                    remaining_d = input_word;
                    seq_d       = '0;
                    total_d     = input_popcount;
                    none_d      = (input_word == '0);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (output_ready) begin
                    remaining_d = remaining_cleared;
                    seq_d       = seq_q + COUNT_WIDTH'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // input_ready follows reset_n directly so it is low throughout reset and rises with release.
    assign input_ready   = (state_q == IDLE) && reset_n;
    assign output_valid  = busy;
    assign output_onehot = busy ? lowest_bit : '0;
    assign output_index  = busy ? lowest_index : '0;
    assign output_seq    = seq_q;
    assign output_total  = total_q;
    assign output_last   = busy && last_beat;
    assign output_none   = busy && none_q;

endmodule

// File: tb/tb_bit_set_enumerator.sv
// Directed bench for bit_set_enumerator: a per-word beat-list model checked every cycle,
// plus literal expectations for each directed scenario and a 5-bit instance.
module tb_bit_set_enumerator;

    localparam int W = 8;

    typedef struct {
        int       idx;
        int       oh;
        int       seq;
        int       total;
        bit       last;
        bit       none;
    } beat_t;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_word;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_index;
    logic [7:0] out_onehot;
    logic [3:0] out_seq;
    logic [3:0] out_total;
    logic       out_last;
    logic       out_none;

    logic       v5;
    logic       r5_in;
    logic [4:0] w5;
    logic       ov5;
    logic       or5;
    logic [2:0] idx5;
    logic [4:0] oh5;
    logic [3:0] seq5;
    logic [3:0] tot5;
    logic       last5;
    logic       none5;

    int checks;
    int failures;
    int cyc;
    int last_hs_cyc;
    int accept_gap;
    beat_t exp_q[$];
    beat_t obs_q[$];

    bit_set_enumerator #(.WORD_WIDTH(8)) dut (
        .clock(clk), .reset_n(reset_n),
        .input_valid(in_valid), .input_ready(in_ready), .input_word(in_word),
        .output_valid(out_valid), .output_ready(out_ready),
        .output_index(out_index), .output_onehot(out_onehot),
        .output_seq(out_seq), .output_total(out_total),
        .output_last(out_last), .output_none(out_none)
    );

    bit_set_enumerator #(.WORD_WIDTH(5)) dut5 (
        .clock(clk), .reset_n(reset_n),
        .input_valid(v5), .input_ready(r5_in), .input_word(w5),
        .output_valid(ov5), .output_ready(or5),
        .output_index(idx5), .output_onehot(oh5),
        .output_seq(seq5), .output_total(tot5),
        .output_last(last5), .output_none(none5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model: the beat list of a word follows directly from its set bits in ascending order.
    task automatic push_word(input logic [7:0] w);
        int n;
        int pop;
        beat_t b;
        pop = $countones(w);
        n = 0;
        if (pop == 0) begin
            b = '{idx: 0, oh: 0, seq: 0, total: 0, last: 1'b1, none: 1'b1};
            exp_q.push_back(b);
        end
        for (int i = 0; i < W; i++) begin
            if (w[i]) begin
                b = '{idx: i, oh: (1 << i), seq: n, total: pop, last: (n == pop - 1), none: 1'b0};
                exp_q.push_back(b);
                n++;
            end
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        beat_t o;
        if (!reset_n) begin
            exp_q.delete();
            chk("reset_valid", {31'd0, out_valid}, 32'd0);
            chk("reset_ready", {31'd0, in_ready}, 32'd0);
        end else begin
            chk("ready_excl_valid", {31'd0, in_ready}, {31'd0, !out_valid});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=idx%0d required=no_beat", out_index);
                end else begin
                    e = exp_q[0];
                    chk("beat_index",  {29'd0, out_index},  e.idx);
                    chk("beat_onehot", {24'd0, out_onehot}, e.oh);
                    chk("beat_seq",    {28'd0, out_seq},    e.seq);
                    chk("beat_total",  {28'd0, out_total},  e.total);
                    chk("beat_last",   {31'd0, out_last},   {31'd0, e.last});
                    chk("beat_none",   {31'd0, out_none},   {31'd0, e.none});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        o = '{idx: int'(out_index), oh: int'(out_onehot), seq: int'(out_seq),
                              total: int'(out_total), last: out_last, none: out_none};
                        obs_q.push_back(o);
                        if (out_last) last_hs_cyc = cyc;
                        $display("beat idx=%0d onehot=%02h seq=%0d total=%0d last=%0d none=%0d",
                                 out_index, out_onehot, out_seq, out_total, out_last, out_none);
                    end
                end
            end
            if (in_valid && in_ready) begin
                push_word(in_word);
                accept_gap = cyc - last_hs_cyc;
                $display("accept word=%02h", in_word);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with valid still high.
    task automatic send_word(input logic [7:0] w);
        bit ok;
        int n;
        in_valid = 1'b1;
        in_word  = w;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_ready && !out_valid && exp_q.size() == 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_seq(input int s);
        int n;
        n = 0;
        while (!(out_valid && int'(out_seq) == s) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("seq_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        last_hs_cyc = 0;
        accept_gap = 0;
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_word = '0;
        out_ready = 1'b1;
        v5 = 1'b0;
        w5 = '0;
        or5 = 1'b1;

        #1;
        chk("rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_ready",  {31'd0, in_ready}, 32'd0);
        chk("rst_seq",    {28'd0, out_seq}, 32'd0);
        chk("rst_total",  {28'd0, out_total}, 32'd0);
        chk("rst_onehot", {24'd0, out_onehot}, 32'd0);
        #21 reset_n = 1'b1;
        #1;
        chk("release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Scenario 1: 0xA5
        obs_q.delete();
        send_word(8'hA5);
        in_valid = 1'b0;
        wait_idle();
        chk("a5_count", obs_q.size(), 32'd4);
        if (obs_q.size() == 4) begin
            chk("a5_idx0", obs_q[0].idx, 32'd0);
            chk("a5_idx1", obs_q[1].idx, 32'd2);
            chk("a5_idx2", obs_q[2].idx, 32'd5);
            chk("a5_idx3", obs_q[3].idx, 32'd7);
            chk("a5_seq3", obs_q[3].seq, 32'd3);
            chk("a5_total", obs_q[1].total, 32'd4);
            chk("a5_last_early", {31'd0, obs_q[2].last}, 32'd0);
            chk("a5_last_final", {31'd0, obs_q[3].last}, 32'd1);
        end

        // Scenario 2: empty word
        obs_q.delete();
        send_word(8'h00);
        in_valid = 1'b0;
        wait_idle();
        chk("zero_count", obs_q.size(), 32'd1);
        if (obs_q.size() == 1) begin
            chk("zero_none",   {31'd0, obs_q[0].none}, 32'd1);
            chk("zero_last",   {31'd0, obs_q[0].last}, 32'd1);
            chk("zero_onehot", obs_q[0].oh, 32'd0);
            chk("zero_total",  obs_q[0].total, 32'd0);
        end

        // Scenario 3: 0xFF with backpressure on beat 2
        obs_q.delete();
        send_word(8'hFF);
        in_valid = 1'b0;
        wait_seq(2);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("hold_index",  {29'd0, out_index}, 32'd2);
            chk("hold_onehot", {24'd0, out_onehot}, 32'h04);
            chk("hold_seq",    {28'd0, out_seq}, 32'd2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_idle();
        chk("ff_count", obs_q.size(), 32'd8);
        if (obs_q.size() == 8) begin
            chk("ff_last_idx", obs_q[7].idx, 32'd7);
            chk("ff_last_seq", obs_q[7].seq, 32'd7);
            chk("ff_total",    obs_q[7].total, 32'd8);
            chk("ff_last",     {31'd0, obs_q[7].last}, 32'd1);
        end

        // Scenario 4: back-to-back words with input_valid held
        obs_q.delete();
        send_word(8'h18);
        send_word(8'h80);
        in_valid = 1'b0;
        wait_idle();
        chk("b2b_gap", accept_gap, 32'd1);
        chk("b2b_count", obs_q.size(), 32'd3);
        if (obs_q.size() == 3) begin
            chk("b2b_idx0", obs_q[0].idx, 32'd3);
            chk("b2b_idx1", obs_q[1].idx, 32'd4);
            chk("b2b_idx2", obs_q[2].idx, 32'd7);
            chk("b2b_total2", obs_q[2].total, 32'd1);
            chk("b2b_last2", {31'd0, obs_q[2].last}, 32'd1);
        end

        // Scenario 5: asynchronous reset mid-stream
        obs_q.delete();
        send_word(8'hF0);
        in_valid = 1'b0;
        wait_seq(2);
        #3 reset_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        chk("after_rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("rst_beats", obs_q.size(), 32'd2);
        if (obs_q.size() == 2) begin
            chk("rst_idx0", obs_q[0].idx, 32'd4);
            chk("rst_idx1", obs_q[1].idx, 32'd5);
        end

        // Scenario 6: 5-bit instance, odd width
        v5 = 1'b1;
        w5 = 5'b10001;
        @(posedge clk);
        #1;
        v5 = 1'b0;
        chk("w5_valid0",  {31'd0, ov5}, 32'd1);
        chk("w5_idx0",    {29'd0, idx5}, 32'd0);
        chk("w5_oh0",     {27'd0, oh5}, 32'h01);
        chk("w5_seq0",    {28'd0, seq5}, 32'd0);
        chk("w5_total",   {28'd0, tot5}, 32'd2);
        chk("w5_last0",   {31'd0, last5}, 32'd0);
        $display("w5 beat idx=%0d onehot=%02h", idx5, oh5);
        @(posedge clk);
        #1;
        chk("w5_idx1",    {29'd0, idx5}, 32'd4);
        chk("w5_oh1",     {27'd0, oh5}, 32'h10);
        chk("w5_seq1",    {28'd0, seq5}, 32'd1);
        chk("w5_last1",   {31'd0, last5}, 32'd1);
        $display("w5 beat idx=%0d onehot=%02h", idx5, oh5);
        @(posedge clk);
        #1;
        chk("w5_done_valid", {31'd0, ov5}, 32'd0);
        chk("w5_done_ready", {31'd0, r5_in}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_set_enumerator.md
Name: bit_set_enumerator

Overview:
Accepts a bitmask word over a valid/ready handshake and emits one output beat per set bit, lowest index first. Each beat carries the bit index, its one-hot mask, a sequence number and the total set-bit count. This is the expansion counterpart of population count: population count turns a mask into a number, and this block turns a mask into a stream of that many items. It is used to walk request/grant masks and to issue one operation per flagged lane.

Parameters:
WORD_WIDTH, 8, width of the input mask; any value >= 2, odd widths allowed.
INDEX_WIDTH, clog2(WORD_WIDTH), width of a bit index; derived, do not set at instantiation.
COUNT_WIDTH, clog2(WORD_WIDTH)+1, width of sequence number and total, wide enough to hold WORD_WIDTH; derived, do not set at instantiation.

Ports:
clock  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
input_valid  input  1  input_word is valid
input_ready  output  1  block can accept a word
input_word  input  WORD_WIDTH  mask to enumerate
output_valid  output  1  current beat valid
output_ready  input  1  downstream accepts beat
output_index  output  INDEX_WIDTH  index of lowest remaining set bit
output_onehot  output  WORD_WIDTH  one-hot of output_index (all zero on empty beat)
output_seq  output  COUNT_WIDTH  0-based beat number within current word
output_total  output  COUNT_WIDTH  number of set bits in the captured word
output_last  output  1  final beat of current word
output_none  output  1  captured word was all zeros

Behaviour:
- Reset: one clock, reset is asynchronous and active-low. Reset forces state to IDLE and clears the remaining-mask register, output_seq and output_total to 0. All outputs are 0 except input_ready, which is 1 as soon as reset_n rises. Reset takes effect immediately, with no clock edge needed.
- Reset mid-stream: output_valid drops at once and the partial word is discarded. No residual beats appear after release.
- States: IDLE, BUSY.
- IDLE:
  - input_ready=1, output_valid=0.
  - On input_valid & input_ready at an edge: capture input_word into the remaining register, set output_seq=0, set output_total=popcount(input_word), set output_none=(input_word==0), then go to BUSY.
- BUSY:
  - input_ready=0, output_valid=1.
  - All outputs are derived from registered state only, with no combinational path from any input to any output.
  - output_onehot = remaining & (~remaining + 1).
  - output_index = priority encode of output_onehot.
  - output_last = 1 when remaining has exactly one bit set, or when output_none=1.
- Output handshake (output_valid & output_ready at an edge):
  - remaining <= remaining & (remaining - 1).
  - output_seq <= output_seq + 1.
  - If output_last was 1, go to IDLE.
- Backpressure: while output_ready=0, every output holds stable.
- Latency: word accepted at edge k gives the first beat visible after edge k. A word with N set bits needs N handshakes (1 if N=0).
- Throughput: one idle cycle between words. input_ready rises the cycle after the last handshake and is never 1 in the same cycle as output_valid.
- Empty word: exactly one beat with output_none=1, output_last=1, output_onehot=0, output_index=0, output_seq=0, output_total=0.
- Full word: WORD_WIDTH beats, output_total=WORD_WIDTH, final output_seq=WORD_WIDTH-1.
- Odd WORD_WIDTH: the top bit is enumerated like any other. No padding bits appear.
- Invariants:
  - output_seq + popcount(remaining) == output_total in BUSY.
  - output_last implies output_seq == output_total-1 (or output_none).
- input_word is ignored whenever input_ready=0. Upstream holding input_valid is safe.

Test Plan:
1. WORD_WIDTH=8, input 0xA5, output_ready=1 -> beats index 0,2,5,7; output_seq 0..3; output_total=4 on every beat; output_last only on index 7; input_ready=1 one cycle later.
2. Input 0x00 -> single beat: output_none=1, output_last=1, output_onehot=0x00, output_total=0; back to IDLE.
3. Input 0xFF, output_ready low for 3 cycles at beat 2 -> index 2, onehot 0x04, seq 2 held stable for all 3 cycles; 8 beats total, last at index 7, total=8.
4. Input 0x18, then 0x80 presented immediately with input_valid held -> input_ready=0 through beats 3,4; 0x80 accepted the cycle after the last handshake; single beat index 7, last=1, total=1.
5. Input 0xF0, assert reset_n low asynchronously mid-cycle after 2 beats -> output_valid=0 immediately; after release, input_ready=1 and no beats for index 6 or 7 ever appear.
6. WORD_WIDTH=5, input 5'b10001 -> beats index 0 then 4; total=2; onehot 5'b00001 then 5'b10000; last on second beat.
